spi_slave_frame_driver: RTL and testbench

SPI_SLAVE_FRAME_DRIVER -- requirements
Module: spi_slave_frame_driver

---
 rtl/spi_slave_frame_driver.sv | 184 ++++++++++++++++++
 tb/tb_spi_slave_frame_driver.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_frame_driver.sv
// spi_slave_frame_driver
//   SPI slave that exchanges one fixed-length frame of DATA_WIDTH*FRAME_WORDS
//   bits per chip-select assertion. The SPI pins are asynchronous to clk and
//   are brought in through 2-flop synchronizers; sclk edges are detected in
//   the clk domain, so clk must run at least 4x sclk.
//
//   Optional feature: define SPI_SLAVE_FRAME_ERROR_EN to build the frame_err
//   logic (pulse on abort and on overrun in DONE). Without it frame_err is
//   tied to 0.
//
// Ports
//   clk        system clock
//   rst        synchronous active-high reset
//   tx_frame   frame returned to the master, word 0 in the MS slice
//   rx_frame   last complete frame received from the master
//   rx_valid   one-cycle pulse when rx_frame updates
//   busy       frame in progress (state ACTIVE)
//   frame_err  one-cycle error pulse (abort / overrun), optional
//   sclk       SPI clock (async)
//   mosi       master data (async)
//   cs         active-low chip select (async)
//   miso       slave data, MSB first
//
// state  | meaning
// IDLE   | waiting for cs low; tx shift register loaded on entry to ACTIVE
// ACTIVE | frame in progress, sampling mosi / shifting miso
// DONE   | full frame received, waiting for cs high; sclk edges ignored
module spi_slave_frame_driver #(
  parameter int DATA_WIDTH  = 8,
  parameter int FRAME_WORDS = 4,
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_WIDTH*FRAME_WORDS-1:0] tx_frame,
  output logic [DATA_WIDTH*FRAME_WORDS-1:0] rx_frame,
  output logic                              rx_valid,
  output logic                              busy,
  output logic                              frame_err,
  input  logic                              sclk,
  input  logic                              mosi,
  input  logic                              cs,
  output logic                              miso
);

  localparam int N  = DATA_WIDTH * FRAME_WORDS;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t          state_q, state_d;
  logic [1:0]      sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic            sclk_prev_q;
  logic [N-1:0]    tx_sr_q, tx_sr_d;
  logic [N-1:0]    rx_sr_q, rx_sr_d;
  logic [N-1:0]    rx_frame_q, rx_frame_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            first_q, first_d;
  logic            rx_valid_q, rx_valid_d;

  logic sclk_s, cs_s, mosi_s;
  logic lead_edge, trail_edge, sample_edge, shift_edge;

  // Synchronizers preset to the bus idle levels so reset never looks like a
  // cs assertion or an sclk edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= {2{CPOL}};
      cs_sync_q   <= 2'b11;
      mosi_sync_q <= 2'b00;
      sclk_prev_q <= CPOL;
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], sclk};
      cs_sync_q   <= {cs_sync_q[0], cs};
      mosi_sync_q <= {mosi_sync_q[0], mosi};
      sclk_prev_q <= sclk_sync_q[1];
    end
  end

  assign sclk_s = sclk_sync_q[1];
  assign cs_s   = cs_sync_q[1];
  assign mosi_s = mosi_sync_q[1];

  // Leading edge moves sclk away from its idle level.
  assign lead_edge   = (sclk_s != CPOL) && (sclk_prev_q == CPOL);
  assign trail_edge  = (sclk_s == CPOL) && (sclk_prev_q != CPOL);
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge  : trail_edge;

`ifdef SPI_SLAVE_FRAME_ERROR_EN
  logic frame_err_q, frame_err_d;
`endif

  always_comb begin
    state_d    = state_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_frame_d = rx_frame_q;
    cnt_d      = cnt_q;
    first_d    = first_q;
    rx_valid_d = 1'b0;
`ifdef SPI_SLAVE_FRAME_ERROR_EN
    frame_err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (!cs_s) begin
          tx_sr_d = tx_frame;
          rx_sr_d = '0;
          cnt_d   = '0;
          first_d = 1'b1;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (sample_edge) begin
          rx_sr_d = (rx_sr_q << 1) | N'(mosi_s);
          cnt_d   = cnt_q + 1'b1;
        end
        if (shift_edge) begin
          // With CPHA=1 the first leading edge only launches bit 0, which
          // is already on miso from the load.
          if (CPHA && first_q) first_d = 1'b0;
          else                 tx_sr_d = tx_sr_q << 1;
        end
        // A final sample edge coinciding with cs release still completes.
        if (sample_edge && (cnt_q == CW'(N - 1))) begin
          rx_frame_d = rx_sr_d;
          rx_valid_d = 1'b1;
          state_d    = cs_s ? IDLE : DONE;
        end else if (cs_s) begin
          state_d = IDLE;
`ifdef SPI_SLAVE_FRAME_ERROR_EN
          frame_err_d = 1'b1;
`endif
        end
      end
      DONE: begin
`ifdef SPI_SLAVE_FRAME_ERROR_EN
        if (sample_edge) frame_err_d = 1'b1;
`endif
        if (cs_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_frame_q <= '0;
      cnt_q      <= '0;
      first_q    <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_frame_q <= rx_frame_d;
      cnt_q      <= cnt_d;
      first_q    <= first_d;
      rx_valid_q <= rx_valid_d;
    end
  end

`ifdef SPI_SLAVE_FRAME_ERROR_EN
  always_ff @(posedge clk) begin
    if (rst) frame_err_q <= 1'b0;
    else     frame_err_q <= frame_err_d;
  end
  assign frame_err = frame_err_q;
`else
  assign frame_err = 1'b0;
`endif

  assign rx_frame = rx_frame_q;
  assign rx_valid = rx_valid_q;
  assign busy     = (state_q == ACTIVE);
  assign miso     = (state_q == ACTIVE) ? tx_sr_q[N-1] : 1'b0;

endmodule

// File: tb/tb_spi_slave_frame_driver.sv
// Bench for spi_slave_frame_driver with DATA_WIDTH=8, FRAME_WORDS=2.
// Three instances cover the SPI modes: 0 = CPOL0/CPHA1, 1 = CPOL0/CPHA0,
// 2 = CPOL1/CPHA1. A directed vector table drives whole frames; the reset
// corner cases are written out by hand.
module tb_spi_slave_frame_driver;

`ifdef SPI_SLAVE_FRAME_ERROR_EN
  localparam int ERR_EN = 1;
`else
  localparam int ERR_EN = 0;
`endif
  localparam int H = 8;  // clk cycles per sclk half-period

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] tx_frame;
  logic        mosi;
  logic        sclk_w [3];
  logic        cs_w   [3];
  logic [15:0] rxf_w  [3];
  logic        rxv_w  [3];
  logic        busy_w [3];
  logic        ferr_w [3];
  logic        miso_w [3];

  always #5 clk = ~clk;

  spi_slave_frame_driver #(.DATA_WIDTH(8), .FRAME_WORDS(2), .CPOL(1'b0), .CPHA(1'b1)) u_m01 (
    .clk(clk), .rst(rst), .tx_frame(tx_frame), .rx_frame(rxf_w[0]), .rx_valid(rxv_w[0]),
    .busy(busy_w[0]), .frame_err(ferr_w[0]), .sclk(sclk_w[0]), .mosi(mosi), .cs(cs_w[0]),
    .miso(miso_w[0]));
  spi_slave_frame_driver #(.DATA_WIDTH(8), .FRAME_WORDS(2), .CPOL(1'b0), .CPHA(1'b0)) u_m00 (
    .clk(clk), .rst(rst), .tx_frame(tx_frame), .rx_frame(rxf_w[1]), .rx_valid(rxv_w[1]),
    .busy(busy_w[1]), .frame_err(ferr_w[1]), .sclk(sclk_w[1]), .mosi(mosi), .cs(cs_w[1]),
    .miso(miso_w[1]));
  spi_slave_frame_driver #(.DATA_WIDTH(8), .FRAME_WORDS(2), .CPOL(1'b1), .CPHA(1'b1)) u_m11 (
    .clk(clk), .rst(rst), .tx_frame(tx_frame), .rx_frame(rxf_w[2]), .rx_valid(rxv_w[2]),
    .busy(busy_w[2]), .frame_err(ferr_w[2]), .sclk(sclk_w[2]), .mosi(mosi), .cs(cs_w[2]),
    .miso(miso_w[2]));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_samp = 0;
  int valid_cnt [3] = '{0, 0, 0};
  int err_cnt   [3] = '{0, 0, 0};
  int last_vcyc [3] = '{0, 0, 0};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rxv_w[k] === 1'b1) begin
        valid_cnt[k] = valid_cnt[k] + 1;
        last_vcyc[k] = cyc;
      end
      if (ferr_w[k] === 1'b1) err_cnt[k] = err_cnt[k] + 1;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Master model: nbits sclk pulses on instance d, recording miso at each
  // master sample point (oldest bit ends up most significant in got).
  task automatic run_frame(input int d, input logic [15:0] tx, input logic [15:0] data,
                           input int nbits, input bit rel, output logic [16:0] got);
    logic cp, ch;
    cp = (d == 2);
    ch = (d != 1);
    got = '0;
    tx_frame = tx;
    cs_w[d] = 1'b0;
    wait_clk(H);
    for (int i = 0; i < nbits; i++) begin
      logic b;
      b = (i < 16) ? data[15-i] : 1'b1;
      if (i == 3) tx_frame = ~tx;
      if (!ch) begin
        mosi = b;
        wait_clk(H);
        got = {got[15:0], miso_w[d]};
        sclk_w[d] = ~cp;
        last_samp = cyc;
        wait_clk(H);
        sclk_w[d] = cp;
      end else begin
        sclk_w[d] = ~cp;
        mosi = b;
        wait_clk(H);
        got = {got[15:0], miso_w[d]};
        sclk_w[d] = cp;
        last_samp = cyc;
      end
      wait_clk(H);
    end
    if (rel) cs_w[d] = 1'b1;
  endtask

  typedef struct {
    int          d;
    logic [15:0] tx;
    logic [15:0] data;
    int          nbits;
    logic [16:0] exp_miso;
    logic [15:0] exp_rx;
    int          exp_valid;
    int          exp_err;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [16:0] got;
    int v0, e0;

    vecs[0] = '{0, 16'hA55A, 16'h3CC3, 16, 17'h0A55A, 16'h3CC3, 1, 0};
    vecs[1] = '{1, 16'hA55A, 16'h3CC3, 16, 17'h0A55A, 16'h3CC3, 1, 0};
    vecs[2] = '{2, 16'hA55A, 16'h3CC3, 16, 17'h0A55A, 16'h3CC3, 1, 0};
    vecs[3] = '{0, 16'h0F0F, 16'h1234, 16, 17'h00F0F, 16'h1234, 1, 0};
    vecs[4] = '{0, 16'hF00F, 16'hFEDC, 16, 17'h0F00F, 16'hFEDC, 1, 0};
    vecs[5] = '{1, 16'hA55A, 16'hFF80, 9,  17'h0014A, 16'h3CC3, 0, ERR_EN};
    vecs[6] = '{2, 16'h5AA5, 16'hC0DE, 17, 17'h0B54A, 16'hC0DE, 1, ERR_EN};

    rst = 1'b1;
    mosi = 1'b0;
    tx_frame = '0;
    for (int k = 0; k < 3; k++) cs_w[k] = 1'b1;
    sclk_w[0] = 1'b0;
    sclk_w[1] = 1'b0;
    sclk_w[2] = 1'b1;
    wait_clk(5);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_rx_frame[%0d]", k), 32'(rxf_w[k]), 32'h0);
      check($sformatf("rst_rx_valid[%0d]", k), 32'(rxv_w[k]), 32'h0);
      check($sformatf("rst_busy[%0d]", k), 32'(busy_w[k]), 32'h0);
      check($sformatf("rst_miso[%0d]", k), 32'(miso_w[k]), 32'h0);
      check($sformatf("rst_frame_err[%0d]", k), 32'(ferr_w[k]), 32'h0);
    end
    rst = 1'b0;
    wait_clk(4);

    for (int v = 0; v < 7; v++) begin
      int d;
      d = vecs[v].d;
      v0 = valid_cnt[d];
      e0 = err_cnt[d];
      run_frame(d, vecs[v].tx, vecs[v].data, vecs[v].nbits, 1'b1, got);
      wait_clk(4);
      check($sformatf("v%0d_miso", v), 32'(got), 32'(vecs[v].exp_miso));
      check($sformatf("v%0d_rx_frame", v), 32'(rxf_w[d]), 32'(vecs[v].exp_rx));
      check($sformatf("v%0d_rx_valid_cnt", v), 32'(valid_cnt[d] - v0), 32'(vecs[v].exp_valid));
      check($sformatf("v%0d_frame_err_cnt", v), 32'(err_cnt[d] - e0), 32'(vecs[v].exp_err));
      check($sformatf("v%0d_busy_after", v), 32'(busy_w[d]), 32'h0);
      if (vecs[v].exp_valid == 1 && vecs[v].nbits == 16)
        check($sformatf("v%0d_rx_valid_latency", v), 32'(last_vcyc[d] - last_samp), 32'd3);
    end

    // Reset in the middle of a frame, then a clean frame.
    v0 = valid_cnt[0];
    e0 = err_cnt[0];
    run_frame(0, 16'h1111, 16'hA000, 5, 1'b0, got);
    check("midrst_busy_before", 32'(busy_w[0]), 32'h1);
    rst = 1'b1;
    cs_w[0] = 1'b1;
    sclk_w[0] = 1'b0;
    wait_clk(3);
    check("midrst_busy", 32'(busy_w[0]), 32'h0);
    check("midrst_rx_frame", 32'(rxf_w[0]), 32'h0);
    check("midrst_miso", 32'(miso_w[0]), 32'h0);
    rst = 1'b0;
    wait_clk(4);
    check("midrst_busy_after_release", 32'(busy_w[0]), 32'h0);
    run_frame(0, 16'h8001, 16'h00FF, 16, 1'b1, got);
    wait_clk(4);
    check("postrst_rx_frame", 32'(rxf_w[0]), 32'h00FF);
    check("postrst_miso", 32'(got), 32'h08001);
    check("postrst_rx_valid_cnt", 32'(valid_cnt[0] - v0), 32'd1);
    check("postrst_frame_err_cnt", 32'(err_cnt[0] - e0), 32'd0);
    check("postrst_rx_valid_latency", 32'(last_vcyc[0] - last_samp), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
